// File: rtl/mu0_pkg.sv
// Shared constants for the mu0 arbitrating mux: word width, arbitration modes, index width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mu0_pkg;

  localparam int MU0_WORD_WIDTH = 12;
  localparam int MU0_ARB_RR     = 0;
  localparam int MU0_ARB_FIXED  = 1;

  // Channel index width; never narrower than one bit so a 1-wide index port always exists.
  function automatic int mu0_cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mu0_rr_arbiter.sv
// Grant generator: round-robin from a last-grant pointer (mode=0) or fixed lowest-index priority (mode=1).
// Latency: grant is combinational from req and the pointer; the pointer updates at the edge of an accepted transfer.
// Backpressure: the pointer only moves when advance is high, so a stalled request keeps its priority slot.
// Ports: clk, reset_n        clock and async active-low reset
//        req[CHANNELS]       per-channel request
//        advance, mode       transfer happened this cycle / 1 = fixed priority
//        grant, grant_idx    one-hot grant and its encoded index
module mu0_rr_arbiter
  import mu0_pkg::*;
#(
  parameter  int CHANNELS = 2,
  localparam int CW       = mu0_cw(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  input  logic                mode,
  output logic [CHANNELS-1:0] grant,
  output logic [CW-1:0]       grant_idx
);

  logic [CW-1:0] ptr_q;
  logic [CW-1:0] ptr_d;
  logic          found;
  int            cand;

  // Scan CHANNELS candidates in priority order; first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (mode) begin
        cand = k;
      end else begin
        // Start one past the last grant and wrap at CHANNELS-1.
        cand = int'(ptr_q) + 1 + k;
        if (cand >= CHANNELS) cand = cand - CHANNELS;
      end
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = CW'(cand);
      end
    end
  end

  // Fixed-priority mode leaves the pointer at its reset value.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && !mode && found) ptr_d = grant_idx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= CW'(CHANNELS - 1);
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mu0_arb_mux.sv
// Arbitrating N:1 mux with a single valid/ready output register stage.
// Latency: 1 cycle from input transfer to out_valid; one word per cycle while out_ready stays high.
// Backpressure: output holds and all in_ready drop while out_valid & !out_ready.
// Ports: clk, reset_n                    clock and async active-low reset
//        in_valid/in_data/in_ready       per-channel request, packed words, accept
//        out_valid/out_data/out_chan     registered word and its source channel
//        out_ready                       downstream accept
module mu0_arb_mux
  import mu0_pkg::*;
#(
  parameter  int WIDTH    = MU0_WORD_WIDTH,
  parameter  int CHANNELS = 2,
  parameter  int MODE     = MU0_ARB_RR,
  localparam int CW       = mu0_cw(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan,
  input  logic                      out_ready
);

  logic                out_valid_q;
  logic [WIDTH-1:0]    out_data_q;
  logic [CW-1:0]       out_chan_q;
  logic                load_en;
  logic                take;
  logic [CHANNELS-1:0] grant;
  logic [CW-1:0]       grant_idx;
  logic [WIDTH-1:0]    sel_data;
  logic                fixed_mode;

  assign fixed_mode = (MODE == MU0_ARB_FIXED);
  assign load_en    = !out_valid_q || out_ready;
  assign take       = load_en && (|grant);

  mu0_rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (in_valid),
    .advance   (take),
    .mode      (fixed_mode),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // reset_n gates ready so nothing is accepted while the register is held clear.
  assign in_ready = grant & {CHANNELS{load_en && reset_n}};

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // With no request the word and channel hold; only the valid flag drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else if (load_en) begin
      out_valid_q <= take;
      if (take) begin
        out_data_q <= sel_data;
        out_chan_q <= grant_idx;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
